stopwatch_timer: RTL and testbench
==================================

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of BCD digits (legal 1..8).
REQ-002 SHALL have parameter DIV_FACTOR, default 50000, clock cycles per count tick (legal >= 2).
REQ-003 SHALL have port clock  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_n  input  1  start/resume button, active-low, asynchronous to clock.
REQ-006 SHALL have port stop_n  input  1  stop button, active-low, asynchronous.
REQ-007 SHALL have port lap_n  input  1  lap button, active-low, asynchronous.
REQ-008 SHALL have port mode_down  input  1  0 = count up, 1 = count down.
REQ-009 SHALL have port load  input  1  synchronous preset load strobe.
REQ-010 SHALL have port preset  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0].
REQ-011 SHALL have port bcd_out  output  4*DIGITS  displayed BCD value.
REQ-012 SHALL have port running  output  1  high in RUN state.
REQ-013 SHALL have port lap_active  output  1  high while bcd_out shows frozen lap value.
REQ-014 SHALL have port done  output  1  one-cycle pulse on down-count expiry.
REQ-015 SHALL have port overflow  output  1  sticky flag, up-count wrapped.

Function
REQ-016 SHALL pass each button through a 2-flop synchroniser and falling-edge detector, giving one-cycle events start_ev, stop_ev, lap_ev; event registered 3 clock edges after button falls; held button yields one event.
REQ-017 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-018 SHALL transition IDLE/PAUSE -> RUN on start_ev; RUN -> PAUSE on stop_ev; RUN -> EXPIRED when a down-count tick yields value 0; EXPIRED -> IDLE only on load.
REQ-019 SHALL give stop_ev priority over start_ev when both occur in one cycle (RUN -> PAUSE; IDLE/PAUSE stay).
REQ-020 SHALL latch mode_down on each start_ev entering RUN; mode_down changes at other times are ignored.
REQ-021 SHALL clear the tick divider on every entry to RUN, advance it only in RUN, hold it in PAUSE, and issue a tick when it equals DIV_FACTOR-1 (then wrap to 0); first tick DIV_FACTOR cycles after the RUN-entry edge.
REQ-022 SHALL on an up tick increment the value as cascaded BCD (digit 9 -> 0 with carry); all-9s -> all-0s sets overflow and counting continues.
REQ-023 SHALL on a down tick decrement as cascaded BCD (digit 0 -> 9 with borrow); reaching all-0s enters EXPIRED with done high that same cycle only.
REQ-024 SHALL, on start_ev in down mode with value 0, enter EXPIRED directly and pulse done once, no counting.
REQ-025 SHALL accept load only in IDLE, PAUSE, EXPIRED: value <= preset with each digit > 9 clamped to 9, state <= IDLE, overflow and lap_active cleared; load in RUN ignored.
REQ-026 SHALL on lap_ev in RUN toggle lap_active; on 0->1 capture current value into lap register; counting continues unaffected.
REQ-027 SHALL on lap_ev outside RUN clear lap_active.
REQ-028 SHALL drive bcd_out = lap register when lap_active, else live value; registered, no combinational input-to-output path.
REQ-029 SHALL, when tick and lap capture coincide, capture the pre-tick value.

Reset
REQ-030 SHALL on Reset_n low immediately force state IDLE, value 0, lap register 0, divider 0, all outputs 0.
REQ-031 SHALL preset synchroniser flops to 1 so reset release with buttons held low generates no event until released and re-pressed.
REQ-032 SHALL abort any operation on mid-run reset with no done pulse.

Verification (DIGITS=2, DIV_FACTOR=4)
REQ-033 SHALL verify up count: start press, mode_down=0 -> running after 3 edges, bcd_out 0x00,0x01,... every 4 cycles; at 0x99 next tick -> 0x00, overflow=1.
REQ-034 SHALL verify down count: load preset 0x03, start, mode_down=1 -> 0x02,0x01,0x00 at 4-cycle spacing; done one cycle with 0x00, state EXPIRED, later start ignored.
REQ-035 SHALL verify pause/resume: stop at 0x05 -> bcd_out holds 0x05 for 20 cycles; start -> 0x06 exactly 4 cycles after RUN re-entry.
REQ-036 SHALL verify lap: lap at 0x07 -> bcd_out frozen 0x07, lap_active=1; second lap at live 0x12 -> bcd_out 0x12, lap_active=0.
REQ-037 SHALL verify simultaneous start and stop in PAUSE -> remains PAUSE; preset 0xA3 loaded -> 0x93.
REQ-038 SHALL verify reset at 0x42 in RUN with start_n held low -> all outputs 0, no event until start_n released and pressed again.

Source files
------------

// File: rtl/stopwatch_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_timer
//   BCD stopwatch / countdown timer with start, stop and lap buttons.
//
//   Parameters
//     DIGITS      number of BCD digits shown (1..8)
//     DIV_FACTOR  clock cycles per count tick (>= 2)
//
//   Ports
//     clock       system clock, rising edge
//     Reset_n     asynchronous active-low reset
//     start_n     start/resume button, active-low, asynchronous
//     stop_n      stop button, active-low, asynchronous
//     lap_n       lap button, active-low, asynchronous
//     mode_down   0 = count up, 1 = count down (sampled on start)
//     load        preset load strobe (ignored while running)
//     preset      BCD preset, digit 0 in bits [3:0]
//     bcd_out     displayed BCD value (lap value while lap_active)
//     running     high while counting
//     lap_active  high while bcd_out shows the frozen lap value
//     done        one-cycle pulse when a down count expires
//     overflow    sticky flag, an up count wrapped past all nines
// ---------------------------------------------------------------------------
module stopwatch_timer #(
    parameter int DIGITS     = 6,
    parameter int DIV_FACTOR = 50000
) (
    input  logic                  clock,
    input  logic                  Reset_n,
    input  logic                  start_n,
    input  logic                  stop_n,
    input  logic                  lap_n,
    input  logic                  mode_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  lap_active,
    output logic                  done,
    output logic                  overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Button synchronisers and falling-edge detectors.
    // Bit order in the vectors: [0] start, [1] stop, [2] lap.
    // ------------------------------------------------------------------
    logic [2:0] btn_s1_q, btn_s1_d;
    logic [2:0] btn_s2_q, btn_s2_d;
    logic [2:0] btn_s3_q, btn_s3_d;
    logic [2:0] armed_q,  armed_d;
    logic [1:0] settle_q, settle_d;
    logic       settled;
    logic       start_ev, stop_ev, lap_ev;

    // The synchroniser presets to "released" for its first two cycles, so
    // a button held through reset would look like a fresh press. A button
    // is only armed once its synchronised level has been seen high after
    // the pipeline has filled with real samples.
    always_comb begin
        settled  = (settle_q == 2'd2);
        settle_d = settled ? settle_q : settle_q + 2'd1;
        btn_s1_d = {lap_n, stop_n, start_n};
        btn_s2_d = btn_s1_q;
        btn_s3_d = btn_s2_q;
        armed_d  = armed_q | ({3{settled}} & btn_s2_q);
    end

    assign start_ev = armed_q[0] & btn_s3_q[0] & ~btn_s2_q[0];
    assign stop_ev  = armed_q[1] & btn_s3_q[1] & ~btn_s2_q[1];
    assign lap_ev   = armed_q[2] & btn_s3_q[2] & ~btn_s2_q[2];

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_s1_q <= 3'b111;
            btn_s2_q <= 3'b111;
            btn_s3_q <= 3'b111;
            armed_q  <= 3'b000;
            settle_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every flop
            // samples the pre-edge value of the others (a real shift chain).
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
            btn_s3_q <= btn_s3_d;
            armed_q  <= armed_d;
            settle_q <= settle_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, counter, divider and lap register
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [W-1:0]  value_q, value_d;
    logic [W-1:0]  lap_q, lap_d;
    logic [DW-1:0] div_q, div_d;
    logic          mode_q, mode_d;
    logic          lap_active_q, lap_active_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          running_q, running_d;
    logic [W-1:0]  bcd_q, bcd_d;
    logic          tick;
    logic [W-1:0]  value_dec;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        value_d      = value_q;
        lap_d        = lap_q;
        div_d        = div_q;
        mode_d       = mode_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;

        tick      = (state_q == RUN) && (div_q == DW'(DIV_FACTOR - 1));
        value_dec = bcd_dec(value_q);

        if (state_q == RUN) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end

        if (load && (state_q != RUN)) begin
            value_d      = bcd_clamp(preset);
            state_d      = IDLE;
            overflow_d   = 1'b0;
            lap_active_d = 1'b0;
        end else begin
            // Lap capture uses value_q, i.e. the value before any tick in
            // this same cycle.
            if (lap_ev) begin
                if (state_q == RUN) begin
                    lap_active_d = ~lap_active_q;
                    if (!lap_active_q) lap_d = value_q;
                end else begin
                    lap_active_d = 1'b0;
                end
            end

            unique case (state_q)
                IDLE, PAUSE: begin
                    // Stop wins over a simultaneous start: nothing happens.
                    if (start_ev && !stop_ev) begin
                        mode_d = mode_down;
                        if (mode_down && (value_q == '0)) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                            div_d   = '0;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (mode_q) begin
                            value_d = value_dec;
                            if (value_dec == '0) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            value_d = bcd_inc(value_q);
                            if (value_q == {DIGITS{4'h9}}) overflow_d = 1'b1;
                        end
                    end
                    // Expiry on this very tick takes precedence over stop.
                    if (stop_ev && (state_d == RUN)) state_d = PAUSE;
                end
                EXPIRED: begin
                    // Only a load leaves EXPIRED.
                end
            endcase
        end

        running_d = (state_d == RUN);
        bcd_d     = lap_active_d ? lap_d : value_d;
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            value_q      <= '0;
            lap_q        <= '0;
            div_q        <= '0;
            mode_q       <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            running_q    <= 1'b0;
            bcd_q        <= '0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            lap_q        <= lap_d;
            div_q        <= div_d;
            mode_q       <= mode_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            running_q    <= running_d;
            bcd_q        <= bcd_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_timer
//   Self-checking bench for stopwatch_timer (DIGITS=2, DIV_FACTOR=4).
//   A cycle-level reference model keeps the count as a plain integer and
//   converts to BCD with arithmetic; directed scenarios add fixed expected
//   values on top, and a random phase compares every cycle to the model.
// ---------------------------------------------------------------------------
module tb_stopwatch_timer;

    localparam int D    = 2;
    localparam int DF   = 4;
    localparam int W    = 4 * D;
    localparam int MAXV = 99;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;

    logic         clock     = 1'b0;
    logic         Reset_n   = 1'b0;
    logic         start_n   = 1'b1;
    logic         stop_n    = 1'b1;
    logic         lap_n     = 1'b1;
    logic         mode_down = 1'b0;
    logic         load      = 1'b0;
    logic [W-1:0] preset    = '0;
    logic [W-1:0] bcd_out;
    logic         running, lap_active, done, overflow;

    int total = 0;
    int bad   = 0;

    stopwatch_timer #(.DIGITS(D), .DIV_FACTOR(DF)) dut (
        .clock     (clock),
        .Reset_n   (Reset_n),
        .start_n   (start_n),
        .stop_n    (stop_n),
        .lap_n     (lap_n),
        .mode_down (mode_down),
        .load      (load),
        .preset    (preset),
        .bcd_out   (bcd_out),
        .running   (running),
        .lap_active(lap_active),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    wire [W+3:0] dut_vec = {bcd_out, running, lap_active, done, overflow};

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int       m_state = S_IDLE, m_val = 0, m_lapv = 0, m_div = 0, m_edges = 0;
    bit       m_mode = 0, m_lapon = 0, m_ovf = 0, m_done = 0, m_tick = 0;
    bit [2:0] h1 = '1, h2 = '1, h3 = '1, m_ev = '0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [W-1:0] p);
        int v, scale, dg;
        v     = 0;
        scale = 1;
        for (int i = 0; i < D; i++) begin
            dg    = int'(p[4*i +: 4]);
            if (dg > 9) dg = 9;
            v     = v + dg * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    function automatic logic [W+3:0] model_vec();
        return {to_bcd(m_lapon ? m_lapv : m_val), (m_state == S_RUN), m_lapon, m_done, m_ovf};
    endfunction

    // A press is seen at the third edge after the first low sample; nothing
    // fires within the first three edges after reset.
    initial forever begin
        @(posedge clock or negedge Reset_n);
        if (!Reset_n) begin
            m_state = S_IDLE; m_val = 0; m_lapv = 0; m_div = 0; m_edges = 0;
            m_mode = 0; m_lapon = 0; m_ovf = 0; m_done = 0;
            h1 = '1; h2 = '1; h3 = '1;
        end else begin
            m_edges++;
            m_ev = (m_edges >= 4) ? (h3 & ~h2) : 3'b000;
            h3 = h2; h2 = h1; h1 = {lap_n, stop_n, start_n};
            m_done = 0;
            m_tick = (m_state == S_RUN) && (m_div == DF - 1);
            if (m_state == S_RUN) m_div = m_tick ? 0 : m_div + 1;
            if (load && m_state != S_RUN) begin
                m_val = clamp_val(preset); m_state = S_IDLE; m_ovf = 0; m_lapon = 0;
            end else begin
                if (m_ev[2]) begin
                    if (m_state == S_RUN) begin
                        if (!m_lapon) m_lapv = m_val;
                        m_lapon = !m_lapon;
                    end else m_lapon = 0;
                end
                if ((m_state == S_IDLE || m_state == S_PAUSE) && m_ev[0] && !m_ev[1]) begin
                    m_mode = mode_down;
                    if (mode_down && m_val == 0) begin m_state = S_EXP; m_done = 1; end
                    else begin m_state = S_RUN; m_div = 0; end
                end else if (m_state == S_RUN) begin
                    if (m_tick) begin
                        if (m_mode) begin
                            m_val = m_val - 1;
                            if (m_val == 0) begin m_state = S_EXP; m_done = 1; end
                        end else if (m_val == MAXV) begin
                            m_val = 0; m_ovf = 1;
                        end else m_val = m_val + 1;
                    end
                    if (m_state == S_RUN && m_ev[1]) m_state = S_PAUSE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge clock);
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (dut_vec !== '0) begin bad++; $display("FAIL reset_zero: got %h want 0", dut_vec); end
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL reset_model: got %h want %h", dut_vec, model_vec()); end
        end
    endtask

    task automatic test_up_count();
        mode_down = 1'b0;
        start_n   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            total++;
            if (running !== (k == 3)) begin bad++; $display("FAIL up_start_latency: edge %0d running %b want %b", k, running, (k == 3)); end
        end
        start_n = 1'b1;
        for (int i = 1; i <= 100 * DF; i++) begin
            @(negedge clock);
            total++;
            if (bcd_out !== to_bcd((i / DF) % 100) || overflow !== (i >= 100 * DF)) begin
                bad++; $display("FAIL up_count: cycle %0d got %h ovf %b want %h ovf %b", i, bcd_out, overflow, to_bcd((i / DF) % 100), (i >= 100 * DF));
            end
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL up_model: got %h want %h", dut_vec, model_vec()); end
        end
    endtask

    task automatic test_pause_resume();
        repeat (5 * DF) @(negedge clock);   // value has just become 05
        stop_n = 1'b0;
        repeat (3) @(negedge clock);
        stop_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if (bcd_out !== 8'h05 || running !== 1'b0) begin bad++; $display("FAIL pause_hold: got %h run %b want 05 run 0", bcd_out, running); end
        end
        start_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            total++;
            if (running !== (k == 3)) begin bad++; $display("FAIL resume_latency: edge %0d running %b", k, running); end
        end
        start_n = 1'b1;
        for (int j = 1; j <= DF; j++) begin
            @(negedge clock);
            total++;
            if (bcd_out !== ((j < DF) ? 8'h05 : 8'h06)) begin bad++; $display("FAIL resume_tick: cycle %0d got %h want %h", j, bcd_out, (j < DF) ? 8'h05 : 8'h06); end
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL resume_model: got %h want %h", dut_vec, model_vec()); end
        end
    endtask

    task automatic test_lap();
        repeat (DF) @(negedge clock);   // live value has just become 07
        lap_n = 1'b0;
        repeat (3) @(negedge clock);
        lap_n = 1'b1;
        total++;
        if (bcd_out !== 8'h07 || lap_active !== 1'b1) begin bad++; $display("FAIL lap_capture: got %h lap %b want 07 lap 1", bcd_out, lap_active); end
        for (int k = 0; k < 5 * DF - 3; k++) begin   // live reaches 12
            @(negedge clock);
            total++;
            if (bcd_out !== 8'h07 || running !== 1'b1) begin bad++; $display("FAIL lap_frozen: got %h run %b want 07 run 1", bcd_out, running); end
        end
        lap_n = 1'b0;
        repeat (3) @(negedge clock);
        lap_n = 1'b1;
        total++;
        if (bcd_out !== 8'h12 || lap_active !== 1'b0) begin bad++; $display("FAIL lap_release: got %h lap %b want 12 lap 0", bcd_out, lap_active); end
        total++;
        if (dut_vec !== model_vec()) begin bad++; $display("FAIL lap_model: got %h want %h", dut_vec, model_vec()); end
    endtask

    task automatic test_down_count();
        stop_n = 1'b0;
        repeat (3) @(negedge clock);
        stop_n = 1'b1;
        @(negedge clock);
        load = 1'b1; preset = 8'h03;
        @(negedge clock);
        load = 1'b0;
        total++;
        if (dut_vec !== {8'h03, 4'b0000}) begin bad++; $display("FAIL down_load: got %h want 030", dut_vec); end
        mode_down = 1'b1;
        start_n   = 1'b0;
        repeat (3) @(negedge clock);
        start_n   = 1'b1;
        mode_down = 1'b0;   // must be ignored once running
        for (int j = 1; j <= 3 * DF; j++) begin
            @(negedge clock);
            total++;
            if (bcd_out !== to_bcd(3 - j / DF) || done !== (j == 3 * DF) || running !== (j < 3 * DF)) begin
                bad++; $display("FAIL down_count: cycle %0d got %h done %b run %b", j, bcd_out, done, running);
            end
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL down_done_width: done %b want 0", done); end
        start_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            total++;
            if (running !== 1'b0 || done !== 1'b0 || bcd_out !== 8'h00) begin bad++; $display("FAIL expired_start: got %h run %b done %b", bcd_out, running, done); end
        end
        start_n = 1'b1;
        total++;
        if (dut_vec !== model_vec()) begin bad++; $display("FAIL down_model: got %h want %h", dut_vec, model_vec()); end
    endtask

    task automatic test_simultaneous();
        @(negedge clock);
        load = 1'b1; preset = 8'h00;
        @(negedge clock);
        load = 1'b0;
        start_n = 1'b0;
        repeat (3) @(negedge clock);
        start_n = 1'b1;
        repeat (5) @(negedge clock);
        stop_n = 1'b0;
        repeat (3) @(negedge clock);
        stop_n = 1'b1;
        repeat (2) @(negedge clock);
        start_n = 1'b0; stop_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            total++;
            if (running !== 1'b0) begin bad++; $display("FAIL simul_pause: running %b want 0", running); end
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL simul_model: got %h want %h", dut_vec, model_vec()); end
        end
        start_n = 1'b1; stop_n = 1'b1;
        @(negedge clock);
        load = 1'b1; preset = 8'hA3;
        @(negedge clock);
        load = 1'b0;
        total++;
        if (bcd_out !== 8'h93) begin bad++; $display("FAIL preset_clamp: got %h want 93", bcd_out); end
    endtask

    task automatic test_reset_held();
        @(negedge clock);
        load = 1'b1; preset = 8'h40;
        @(negedge clock);
        load = 1'b0;
        start_n = 1'b0;
        repeat (3) @(negedge clock);
        repeat (2 * DF) @(negedge clock);
        total++;
        if (bcd_out !== 8'h42 || running !== 1'b1) begin bad++; $display("FAIL pre_reset: got %h run %b want 42 run 1", bcd_out, running); end
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", dut_vec); end
        @(negedge clock);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if (running !== 1'b0 || dut_vec !== '0) begin bad++; $display("FAIL held_button: got %h want 0", dut_vec); end
        end
        start_n = 1'b1;
        repeat (2) @(negedge clock);
        start_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            total++;
            if (running !== (k == 3)) begin bad++; $display("FAIL repress: edge %0d running %b", k, running); end
        end
        start_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL random_model: cycle %0d got %h want %h", c, dut_vec, model_vec()); end
            if ($urandom_range(0, 9) == 0)  start_n = ~start_n;
            if ($urandom_range(0, 24) == 0) stop_n  = ~stop_n;
            if ($urandom_range(0, 14) == 0) lap_n   = ~lap_n;
            if ($urandom_range(0, 19) == 0) mode_down = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 39) == 0);
            preset = W'($urandom);
        end
        start_n = 1'b1; stop_n = 1'b1; lap_n = 1'b1; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_pause_resume();
        test_lap();
        test_down_count();
        test_simultaneous();
        test_reset_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
